date_keeper: RTL and testbench
==============================

Name: date_keeper

Overview:
- Holds the current calendar date (day, month, year, weekday) and advances it on a once-per-day tick from the time-of-day counter.
- Provides `first_wday_o` (weekday of the 1st of the current month) and `mdays_o` (days in the current month). The calendar renderer uses both to place day numbers in its 7-column table.
- Accepts a user "set date" request and recomputes both weekdays with a multi-cycle walk from a fixed epoch.
- Its outputs drive the `date_if` bundle consumed by the calendar drawing stage.

Parameters:
- BASE_YEAR, 2000, calendar year represented by year code 0 (informational; epoch 2000-01-01 is a Saturday).
- YEAR_W, 7, width of the year code; legal codes are 0..99 (years 2000..2099).
- RST_DAY, 1, day loaded at reset.
- RST_MONTH, 1, month loaded at reset.
- RST_YEAR, 0, year code loaded at reset.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- day_tick_i  in  1  single-cycle pulse at midnight.
- set_i  in  1  single-cycle request to load `set_*`.
- set_day_i  in  5  requested day, 1..31.
- set_month_i  in  4  requested month, 1..12.
- set_year_i  in  YEAR_W  requested year code.
- day_o  out  5  current day.
- month_o  out  4  current month.
- year_o  out  YEAR_W  current year code.
- wday_o  out  3  weekday of the current day, 0=Mon .. 6=Sun.
- first_wday_o  out  3  weekday of the 1st of the current month.
- mdays_o  out  5  days in the current month.
- busy_o  out  1  set computation in progress.
- err_o  out  1  one-cycle pulse: set request rejected.

Behaviour:
- Reset (async, rst_i=1):
  - day=RST_DAY, month=RST_MONTH, year=RST_YEAR.
  - wday=5, first_wday=5; defaults correspond to 2000-01-01.
  - busy=0, err=0, pending tick cleared, FSM in IDLE.
  - Reset mid-computation aborts it with no partial commit.
- Leap rule: leap iff year_code[1:0]==0 (exact for 2000..2099).
- `mdays_o` is combinational from the registered month/year: 31/30/28/29 per month, Feb = 29 when leap.
- Tick in IDLE: all outputs update in the cycle after `day_tick_i`.
  - wday = (wday+1) mod 7.
  - If day<mdays: day+1.
  - Otherwise day=1 and first_wday=(wday+1) mod 7, and the month rolls:
    - if month<12: month+1;
    - otherwise month=1 and year = (year==99) ? 0 : year+1.
- Set validation (sampled in IDLE): reject if any of the following holds.
  - month==0 or month>12.
  - year>99.
  - day==0 or day > mdays(month,year).
  - On reject: err_o=1 for the next cycle, no state change, busy stays 0.
- Set FSM, for an accepted set with Y=year code and M=month:
  - IDLE: on accepted set, capture the request and load acc=5. Go to YEAR_WALK if Y>0, else MONTH_WALK if M>1, else COMMIT.
  - YEAR_WALK: exactly Y cycles, one year y=0..Y-1 per cycle; acc = (acc + (leap(y)?2:1)) mod 7. Then go to MONTH_WALK if M>1, else COMMIT.
  - MONTH_WALK: exactly M-1 cycles, one month m=1..M-1 per cycle; acc = (acc + mdays(m,Y) mod 7) mod 7.
  - COMMIT: one cycle; atomically load day, month, year, first_wday=acc, wday=(acc+day-1) mod 7. Return to IDLE.
- Busy window and latency:
  - busy_o is high for Y+(M-1)+1 cycles.
  - The new date is visible at cycle Y+M+1, where the cycle in which set_i is sampled is cycle 0.
  - While busy, all outputs keep the old date.
- Simultaneous and overlapping events:
  - set_i while busy: ignored, no err.
  - day_tick_i while busy, or together with an accepted set in IDLE: sets a 1-deep pending flag. The pending tick is applied in the cycle after COMMIT, advancing the newly set date; additional ticks while pending are dropped.
  - set_i together with day_tick_i, where the set is rejected: the tick is applied normally and err pulses.

Decomposition:
- Shared package `cal_pkg`:
  - weekday enum MON..SUN (0..6);
  - YEAR_W;
  - functions is_leap(year) and month_days(month, year);
  - epoch weekday constant (5).
- The calendar draw stage reuses the same package for its table layout.
- Sub-module `wday_calc`: the IDLE/YEAR_WALK/MONTH_WALK/COMMIT walker. Inputs are start, year and month; outputs are busy, done pulse and first_wday.
- date_keeper owns the date registers, validation, tick logic and the pending flag.

Test Plan:
- Reset -> day=1, month=1, year=0, wday=5, first_wday=5, mdays=31, busy=0.
- Set 2025-03-15 (Y=25, M=3, d=15) -> busy high for exactly 28 cycles; then first_wday=5, wday=5, mdays=31.
- Set 2024-02-28 and wait for commit, then 2 ticks -> 2024-02-29 (mdays=29, wday=3), then 2024-03-01 (first_wday=4, wday=4).
- Set 2099-12-31, then 1 tick -> wrap to year 0, month 1, day 1, first_wday=wday=(previous wday+1) mod 7.
- Set 2023-02-29 -> err_o pulses exactly one cycle, busy stays 0, date unchanged; also check month 13 and day 0 are rejected the same way.
- Set 2025-03-15, pulse day_tick_i twice during busy -> after commit exactly one tick applied: 2025-03-16, wday=6.

Source files
------------

// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - calendar types, constants and month-length helpers shared by date and draw stages
package cal_pkg;

    localparam int YEAR_W = 7;

    typedef enum logic [2:0] {MON, TUE, WED, THU, FRI, SAT, SUN} wday_e;

    // 2000-01-01 was a Saturday
    localparam wday_e EPOCH_WDAY = SAT;

    // Exact for 2000..2099: 2000 is a leap year and 2100 is out of range
    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return year[1:0] == 2'b00;
    endfunction

    function automatic logic [4:0] month_days(input logic [3:0] month, input logic [YEAR_W-1:0] year);
        case (month)
            4'd2:                     month_days = is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  month_days = 5'd30;
            default:                  month_days = 5'd31;
        endcase
    endfunction

    function automatic logic [2:0] wday_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
    endfunction

endpackage

// File: rtl/wday_calc.sv
// rtl/wday_calc.sv - walks from the epoch one year, then one month, per cycle to find the weekday of the 1st
module wday_calc
    import cal_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [YEAR_W-1:0] year,
    input  logic [3:0]        month,
    output logic              busy,
    output logic              done,
    output logic [2:0]        first_wday
);

    typedef enum logic [1:0] {IDLE, YEAR_WALK, MONTH_WALK, COMMIT} state_e;

    state_e            state, state_nxt;
    logic [YEAR_W-1:0] y_tgt, y_idx;
    logic [3:0]        m_tgt, m_idx;
    logic [2:0]        acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (year != '0)          state_nxt = YEAR_WALK;
                    else if (month > 4'd1)   state_nxt = MONTH_WALK;
                    else                     state_nxt = COMMIT;
                end
            end
            YEAR_WALK: begin
                if (y_idx == y_tgt - YEAR_W'(1))
                    state_nxt = (m_tgt > 4'd1) ? MONTH_WALK : COMMIT;
            end
            MONTH_WALK: begin
                if (m_idx == m_tgt - 4'd1) state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= EPOCH_WDAY;
            y_tgt <= '0;
            y_idx <= '0;
            m_tgt <= 4'd1;
            m_idx <= 4'd1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= EPOCH_WDAY;
                        y_tgt <= year;
                        m_tgt <= month;
                        y_idx <= '0;
                        m_idx <= 4'd1;
                    end
                end
                YEAR_WALK: begin
                    acc   <= wday_add(acc, is_leap(y_idx) ? 3'd2 : 3'd1);
                    y_idx <= y_idx + YEAR_W'(1);
                end
                MONTH_WALK: begin
                    acc   <= wday_add(acc, 3'(month_days(m_idx, y_tgt) % 5'd7));
                    m_idx <= m_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == COMMIT);
    assign first_wday = acc;

endmodule

// File: rtl/date_keeper.sv
// rtl/date_keeper.sv - current calendar date with midnight advance and validated, walked set-date loading
module date_keeper #(
    parameter int BASE_YEAR = 2000,
    parameter int YEAR_W    = cal_pkg::YEAR_W,
    parameter int RST_DAY   = 1,
    parameter int RST_MONTH = 1,
    parameter int RST_YEAR  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              day_tick_i,
    input  logic              set_i,
    input  logic [4:0]        set_day_i,
    input  logic [3:0]        set_month_i,
    input  logic [YEAR_W-1:0] set_year_i,
    output logic [4:0]        day_o,
    output logic [3:0]        month_o,
    output logic [YEAR_W-1:0] year_o,
    output logic [2:0]        wday_o,
    output logic [2:0]        first_wday_o,
    output logic [4:0]        mdays_o,
    output logic              busy_o,
    output logic              err_o
);
    import cal_pkg::*;

    // Highest year code whose leap rule is still exact (2099)
    localparam logic [YEAR_W-1:0] LAST_CODE = YEAR_W'(2099 - BASE_YEAR);

    logic [4:0]        req_day;
    logic [3:0]        req_month;
    logic [YEAR_W-1:0] req_year;
    logic              pending;
    logic              set_ok, accept, tick_now;
    logic              walk_busy, walk_done;
    logic [2:0]        walk_first;

    assign mdays_o = month_days(month_o, year_o);
    assign busy_o  = walk_busy;

    always_comb begin
        set_ok = (set_month_i != 4'd0) && (set_month_i <= 4'd12) &&
                 (set_year_i <= LAST_CODE) && (set_day_i != 5'd0) &&
                 (set_day_i <= month_days(set_month_i, set_year_i));
    end

    assign accept   = set_i & ~walk_busy & set_ok;
    // A tick held back by a set is replayed once the walker is idle again
    assign tick_now = (day_tick_i | pending) & ~walk_busy & ~accept;

    wday_calc u_wday_calc (
        .clk        (clk_i),
        .rst        (rst_i),
        .start      (accept),
        .year       (set_year_i),
        .month      (set_month_i),
        .busy       (walk_busy),
        .done       (walk_done),
        .first_wday (walk_first)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            day_o        <= 5'(RST_DAY);
            month_o      <= 4'(RST_MONTH);
            year_o       <= YEAR_W'(RST_YEAR);
            wday_o       <= EPOCH_WDAY;
            first_wday_o <= EPOCH_WDAY;
            req_day      <= 5'(RST_DAY);
            req_month    <= 4'(RST_MONTH);
            req_year     <= YEAR_W'(RST_YEAR);
            pending      <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            err_o <= set_i & ~walk_busy & ~set_ok;

            if (walk_busy)   pending <= pending | day_tick_i;
            else if (accept) pending <= pending | day_tick_i;
            else             pending <= 1'b0;

            if (accept) begin
                req_day   <= set_day_i;
                req_month <= set_month_i;
                req_year  <= set_year_i;
            end

            if (walk_done) begin
                day_o        <= req_day;
                month_o      <= req_month;
                year_o       <= req_year;
                first_wday_o <= walk_first;
                wday_o       <= wday_add(walk_first, 3'((req_day - 5'd1) % 5'd7));
            end else if (tick_now) begin
                wday_o <= wday_add(wday_o, 3'd1);
                if (day_o < mdays_o) begin
                    day_o <= day_o + 5'd1;
                end else begin
                    day_o        <= 5'd1;
                    first_wday_o <= wday_add(wday_o, 3'd1);
                    if (month_o < 4'd12) begin
                        month_o <= month_o + 4'd1;
                    end else begin
                        month_o <= 4'd1;
                        year_o  <= (year_o == LAST_CODE) ? '0 : year_o + YEAR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_date_keeper.sv
// tb/tb_date_keeper.sv - scoreboard bench for date_keeper with directed set/tick vectors
module tb_date_keeper;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       day_tick_i = 1'b0;
    logic       set_i = 1'b0;
    logic [4:0] set_day_i = 5'd0;
    logic [3:0] set_month_i = 4'd0;
    logic [6:0] set_year_i = 7'd0;
    logic [4:0] day_o;
    logic [3:0] month_o;
    logic [6:0] year_o;
    logic [2:0] wday_o;
    logic [2:0] first_wday_o;
    logic [4:0] mdays_o;
    logic       busy_o;
    logic       err_o;

    always #5 clk = ~clk;

    date_keeper dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .day_tick_i   (day_tick_i),
        .set_i        (set_i),
        .set_day_i    (set_day_i),
        .set_month_i  (set_month_i),
        .set_year_i   (set_year_i),
        .day_o        (day_o),
        .month_o      (month_o),
        .year_o       (year_o),
        .wday_o       (wday_o),
        .first_wday_o (first_wday_o),
        .mdays_o      (mdays_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic       err;
        logic [4:0] day;
        logic [3:0] month;
        logic [6:0] year;
        logic [2:0] wday;
        logic [2:0] first;
        logic [4:0] mdays;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t snap();
        obs_t o;
        o.err   = err_o;
        o.day   = day_o;
        o.month = month_o;
        o.year  = year_o;
        o.wday  = wday_o;
        o.first = first_wday_o;
        o.mdays = mdays_o;
        return o;
    endfunction

    task automatic push(input logic e, input int d, input int m, input int y,
                        input int wd, input int fw, input int md);
        obs_t o;
        o.err   = e;
        o.day   = 5'(d);
        o.month = 4'(m);
        o.year  = 7'(y);
        o.wday  = 3'(wd);
        o.first = 3'(fw);
        o.mdays = 5'(md);
        exp_q.push_back(o);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic issue_set(input int d, input int m, input int y);
        @(negedge clk);
        set_day_i   = 5'(d);
        set_month_i = 4'(m);
        set_year_i  = 7'(y);
        set_i       = 1'b1;
        @(negedge clk);
        set_i       = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        day_tick_i = 1'b1;
        @(negedge clk);
        day_tick_i = 1'b0;
    endtask

    // Counts busy cycles from cycle 1; optionally injects ticks at the given offsets
    task automatic wait_busy(input string name, input int want, input int t0, input int t1);
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 400) begin
            day_tick_i = (n == t0 || n == t1);
            n++;
            @(negedge clk);
        end
        day_tick_i = 1'b0;
        chk(name, n, want);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every visible date change or err pulse consumes one expected entry
    initial begin : monitor
        obs_t cur, prev, e;
        wait (rst_i == 1'b0);
        prev = snap();
        forever begin
            @(negedge clk);
            cur = snap();
            if (cur.err || {cur.day, cur.month, cur.year, cur.wday, cur.first} !=
                           {prev.day, prev.month, prev.year, prev.wday, prev.first}) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got err=%0b %0d-%0d-%0d wd=%0d fw=%0d md=%0d",
                             cur.err, cur.year, cur.month, cur.day, cur.wday, cur.first, cur.mdays);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL event got err=%0b %0d-%0d-%0d wd=%0d fw=%0d md=%0d want err=%0b %0d-%0d-%0d wd=%0d fw=%0d md=%0d",
                                 cur.err, cur.year, cur.month, cur.day, cur.wday, cur.first, cur.mdays,
                                 e.err, e.year, e.month, e.day, e.wday, e.first, e.mdays);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_day", day_o, 1);
        chk("rst_month", month_o, 1);
        chk("rst_year", year_o, 0);
        chk("rst_wday", wday_o, 5);
        chk("rst_first_wday", first_wday_o, 5);
        chk("rst_mdays", mdays_o, 31);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);

        // 2025-03-15: Saturday, March 1st also Saturday
        push(0, 15, 3, 25, 5, 5, 31);
        issue_set(15, 3, 25);
        wait_busy("busy_2025_03_15", 28, -1, -1);

        // 2024-02-28 Wed, then leap day Thu, then March 1st Fri
        push(0, 28, 2, 24, 2, 3, 29);
        issue_set(28, 2, 24);
        wait_busy("busy_2024_02_28", 26, -1, -1);
        push(0, 29, 2, 24, 3, 3, 29);
        tick();
        push(0, 1, 3, 24, 4, 4, 31);
        tick();
        repeat (2) @(negedge clk);

        // 2099-12-31 Thu wraps to code 0, Jan 1, Fri
        push(0, 31, 12, 99, 3, 1, 31);
        issue_set(31, 12, 99);
        wait_busy("busy_2099_12_31", 111, -1, -1);
        push(0, 1, 1, 0, 4, 4, 31);
        tick();
        repeat (2) @(negedge clk);

        // Rejected sets leave 2000-01-01 (Fri) untouched
        push(1, 1, 1, 0, 4, 4, 31);
        issue_set(29, 2, 23);
        chk("rej_feb29_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        push(1, 1, 1, 0, 4, 4, 31);
        issue_set(5, 13, 10);
        chk("rej_month13_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        push(1, 1, 1, 0, 4, 4, 31);
        issue_set(0, 5, 10);
        chk("rej_day0_busy", busy_o, 0);
        repeat (3) @(negedge clk);

        // Two ticks during the walk collapse into one applied after commit
        push(0, 15, 3, 25, 5, 5, 31);
        push(0, 16, 3, 25, 6, 5, 31);
        issue_set(15, 3, 25);
        wait_busy("busy_pending", 28, 0, 5);
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
